// File: rtl/warp_ahbs_sram.sv
// AHB-Lite/AHB5 subordinate in front of a word-addressed SRAM, with wait states and two-cycle ERROR.
// Optional exclusive-access monitor enabled by defining WARP_AHBS_EXCL_EN.
module warp_ahbs_sram #(
    parameter int data_width  = 64,
    parameter int depth       = 512,
    parameter int addr_width  = 64,
    parameter int wait_states = 0
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_ahb_hsel,
    input  logic [addr_width-1:0]   i_ahb_haddr,
    input  logic [1:0]              i_ahb_htrans,
    input  logic [2:0]              i_ahb_hsize,
    input  logic                    i_ahb_hwrite,
    input  logic                    i_ahb_hexcl,
    input  logic [2:0]              i_ahb_hburst,
    input  logic [3:0]              i_ahb_hprot,
    input  logic                    i_ahb_hmastlock,
    input  logic                    i_ahb_hnonsec,
    input  logic                    i_ahb_hready,
    input  logic [data_width-1:0]   i_ahb_hwdata,
    input  logic [data_width/8-1:0] i_ahb_hwstrb,
    output logic [data_width-1:0]   o_ahb_hrdata,
    output logic                    o_ahb_hreadyout,
    output logic                    o_ahb_hresp,
    output logic                    o_ahb_hexokay
);
    localparam int nbytes = data_width / 8;
    localparam int lg     = $clog2(nbytes);
    localparam int idx_w  = (depth > 1) ? $clog2(depth) : 1;

    typedef enum logic [1:0] {NONE, XFER, ERR1, ERR2} state_t;

    state_t                  state, state_nxt;
    logic [2:0]              cnt, cnt_nxt;
    logic                    ready_now, resp_now;
    logic                    accept, acc_err, final_xfer;
    logic [idx_w-1:0]        idx_p1;
    logic [lg-1:0]           off_p1;
    logic [2:0]              size_p1;
    logic                    write_p1;
    logic [nbytes-1:0]       wr_be, fwd_be;
    logic                    rd_en;
    logic [idx_w-1:0]        rd_idx;
    logic [data_width-1:0]   rdata;
    logic [data_width-1:0]   mem [depth];
    logic                    unused_ctl;

    function automatic logic [nbytes-1:0] lane_mask(input logic [2:0] size, input logic [lg-1:0] off);
        logic [nbytes-1:0] m;
        m = '0;
        for (int b = 0; b < nbytes; b++)
            if (b >= int'(off) && b < int'(off) + (1 << size))
                m[b] = 1'b1;
        return m;
    endfunction

    function automatic logic addr_error(input logic [addr_width-1:0] addr, input logic [2:0] size);
        logic [addr_width-1:0] align_mask;
        if (int'(size) > lg)
            return 1'b1;
        align_mask = (addr_width'(1) << size) - addr_width'(1);
        return ((addr & align_mask) != '0) || ((addr >> lg) >= addr_width'(depth));
    endfunction

    function automatic logic [data_width-1:0] merge_bytes(input logic [data_width-1:0] old_word,
                                                          input logic [data_width-1:0] new_word,
                                                          input logic [nbytes-1:0]     be);
        logic [data_width-1:0] w;
        w = old_word;
        for (int b = 0; b < nbytes; b++)
            if (be[b])
                w[b*8 +: 8] = new_word[b*8 +: 8];
        return w;
    endfunction

    // Own readiness gates acceptance so address inputs are ignored while this data phase stalls.
    assign ready_now  = (state == NONE) || (state == ERR2) || (state == XFER && cnt == '0);
    assign accept     = i_ahb_hsel && i_ahb_hready && i_ahb_htrans[1] && ready_now;
    assign acc_err    = addr_error(i_ahb_haddr, i_ahb_hsize);
    assign final_xfer = (state == XFER) && (cnt == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= NONE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        resp_now  = 1'b0;
        case (state)
            NONE: ;
            XFER: if (cnt != '0) cnt_nxt = cnt - 3'd1;
            ERR1: begin
                resp_now  = 1'b1;
                state_nxt = ERR2;
            end
            ERR2: resp_now = 1'b1;
        endcase
        if (ready_now) begin
            if (accept) begin
                state_nxt = acc_err ? ERR1 : XFER;
                cnt_nxt   = acc_err ? 3'd0 : 3'(wait_states);
            end else begin
                state_nxt = NONE;
                cnt_nxt   = '0;
            end
        end
    end

    // Address phase -> data phase
    always_ff @(posedge i_clk) begin
        if (accept && !acc_err) begin
            idx_p1   <= i_ahb_haddr[lg +: idx_w];
            off_p1   <= i_ahb_haddr[lg-1:0];
            size_p1  <= i_ahb_hsize;
            write_p1 <= i_ahb_hwrite;
        end
    end

`ifdef WARP_AHBS_EXCL_EN
    logic             excl_p1;
    logic             resv_vld;
    logic [idx_w-1:0] resv_idx;
    logic             resv_match;

    assign resv_match = resv_vld && (resv_idx == idx_p1);

    always_ff @(posedge i_clk) begin
        if (accept && !acc_err)
            excl_p1 <= i_ahb_hexcl;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            resv_vld <= 1'b0;
        end else if (final_xfer) begin
            if (!write_p1 && excl_p1)
                resv_vld <= 1'b1;
            else if (write_p1 && resv_match)
                resv_vld <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (final_xfer && !write_p1 && excl_p1)
            resv_idx <= idx_p1;
    end

    assign o_ahb_hexokay = final_xfer && excl_p1 && (!write_p1 || resv_match);
`else
    logic unused_excl;
    assign unused_excl   = i_ahb_hexcl;
    assign o_ahb_hexokay = 1'b0;
`endif

    always_comb begin
        wr_be = '0;
        if (final_xfer && write_p1)
            wr_be = lane_mask(size_p1, off_p1) & i_ahb_hwstrb;
`ifdef WARP_AHBS_EXCL_EN
        if (excl_p1 && !resv_match)
            wr_be = '0;
`endif
    end

    // With no wait states the read shares its edge with acceptance, so it indexes from haddr directly.
    always_comb begin
        if (wait_states == 0) begin
            rd_en  = accept && !acc_err && !i_ahb_hwrite;
            rd_idx = i_ahb_haddr[lg +: idx_w];
        end else begin
            rd_en  = (state == XFER) && !write_p1 && (cnt == 3'd1);
            rd_idx = idx_p1;
        end
        fwd_be = (rd_idx == idx_p1) ? wr_be : '0;
    end

    // Data phase commit
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < nbytes; b++)
            if (wr_be[b])
                mem[idx_p1][b*8 +: 8] <= i_ahb_hwdata[b*8 +: 8];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            rdata <= '0;
        else if (rd_en)
            rdata <= merge_bytes(mem[rd_idx], i_ahb_hwdata, fwd_be);
    end

    assign o_ahb_hrdata    = rdata;
    assign o_ahb_hreadyout = ready_now;
    assign o_ahb_hresp     = resp_now;

    assign unused_ctl = ^{i_ahb_hburst, i_ahb_hprot, i_ahb_hmastlock, i_ahb_hnonsec, i_ahb_htrans[0]};

endmodule
